// File: rtl/gci_std_display_fb_reader.sv
// Framebuffer read sequencer: streams one display area from memory through a small pixel FIFO.
// Optional sticky underflow detection is enabled by defining GCI_STD_DISPLAY_FB_READER_UNDERFLOW_EN.
//
// state   | meaning
// IDLE    | waiting for iIF_START, returns discarded
// READ    | issuing credited reads, streaming pixels
// END     | one-cycle finish pulse
module gci_std_display_fb_reader #(
  parameter int P_AREA_H       = 640,
  parameter int P_AREA_V       = 480,
  parameter int P_AREAA_HV_N   = 19,
  parameter int P_MEM_ADDR_N   = 23,
  parameter int P_FIFO_DEPTH   = 16,
  parameter int P_FIFO_DEPTH_N = 4
)(
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iIF_START,
  input  logic [P_MEM_ADDR_N-1:0] iIF_BASE_ADDR,
  output logic                    oIF_BUSY,
  output logic                    oIF_FINISH,
  output logic                    oMEM_REQ,
  input  logic                    iMEM_BUSY,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  input  logic                    iMEM_RD_VALID,
  input  logic [23:0]             iMEM_RD_DATA,
  output logic                    oPIX_VALID,
  input  logic                    iPIX_BUSY,
  output logic [23:0]             oPIX_DATA,
  output logic                    oUNDERFLOW
);
  localparam int CW = P_FIFO_DEPTH_N + 1;
  localparam logic [P_AREAA_HV_N-1:0] L_TOTAL = P_AREAA_HV_N'(P_AREA_H * P_AREA_V);
  localparam logic [P_AREAA_HV_N-1:0] L_LAST  = P_AREAA_HV_N'(P_AREA_H * P_AREA_V - 1);
  localparam logic [CW-1:0] L_DEPTH = CW'(P_FIFO_DEPTH);
  localparam logic [CW:0]   L_DEPTH_X = (CW+1)'(P_FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_END} state_t;

  state_t                      state, state_next;
  logic [P_MEM_ADDR_N-1:0]     base;
  logic [P_AREAA_HV_N-1:0]     req_cnt, pix_cnt;
  logic [CW-1:0]               fifo_cnt, outstanding;
  logic [P_FIFO_DEPTH_N-1:0]   wptr, rptr;
  logic [23:0]                 fifo_mem [P_FIFO_DEPTH];
  logic                        start_ok, can_issue, mem_req, pix_valid, finish, push, ret;

  // Credit covers data already buffered plus data still in flight.
  assign can_issue = (req_cnt < L_TOTAL) &&
                     (({1'b0, fifo_cnt} + {1'b0, outstanding}) < L_DEPTH_X);
  assign push = iMEM_RD_VALID && (state != ST_IDLE) && (fifo_cnt != L_DEPTH);
  assign ret  = iMEM_RD_VALID && (state != ST_IDLE) && (outstanding != '0);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)         state <= ST_IDLE;
    else if (iRESET_SYNC) state <= ST_IDLE;
    else                  state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    mem_req    = 1'b0;
    pix_valid  = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iIF_START) begin
          start_ok   = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        mem_req   = can_issue && !iMEM_BUSY;
        pix_valid = (fifo_cnt != '0) && !iPIX_BUSY;
        // Leave on the final pop so the finish pulse lands one cycle after it.
        if ((pix_cnt == L_TOTAL) || (pix_valid && (pix_cnt == L_LAST)))
          state_next = ST_END;
      end
      ST_END: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      base <= '0; req_cnt <= '0; pix_cnt <= '0;
      fifo_cnt <= '0; outstanding <= '0; wptr <= '0; rptr <= '0;
    end else if (iRESET_SYNC || start_ok) begin
      base <= iRESET_SYNC ? '0 : iIF_BASE_ADDR;
      req_cnt <= '0; pix_cnt <= '0;
      fifo_cnt <= '0; outstanding <= '0; wptr <= '0; rptr <= '0;
    end else begin
      if (mem_req)   req_cnt <= req_cnt + 1'b1;
      if (push)      wptr <= wptr + 1'b1;
      if (pix_valid) begin
        rptr    <= rptr + 1'b1;
        pix_cnt <= pix_cnt + 1'b1;
      end
      fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pix_valid);
      outstanding <= outstanding + CW'(mem_req) - CW'(ret);
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < P_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (iRESET_SYNC) begin
      for (int i = 0; i < P_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push && !start_ok) begin
      fifo_mem[wptr] <= iMEM_RD_DATA;
    end
  end

`ifdef GCI_STD_DISPLAY_FB_READER_UNDERFLOW_EN
  logic underflow;
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)                     underflow <= 1'b0;
    else if (iRESET_SYNC || start_ok) underflow <= 1'b0;
    else if ((state == ST_READ) && (pix_cnt != '0) && (pix_cnt < L_TOTAL) &&
             (fifo_cnt == '0) && !iPIX_BUSY)
      underflow <= 1'b1;
  end
  assign oUNDERFLOW = underflow;
`else
  assign oUNDERFLOW = 1'b0;
`endif

  assign oIF_BUSY   = (state != ST_IDLE);
  assign oIF_FINISH = finish;
  assign oMEM_REQ   = mem_req;
  assign oMEM_ADDR  = base + P_MEM_ADDR_N'(req_cnt);
  assign oPIX_VALID = pix_valid;
  assign oPIX_DATA  = fifo_mem[rptr];
endmodule

// File: doc/gci_std_display_fb_reader.md
# gci_std_display_fb_reader

Framebuffer read sequencer: on a frame-start request it issues sequential read requests for one full display area (P_AREA_H × P_AREA_V pixels) to the display memory port. It buffers the in-order read returns in an internal FIFO and streams 24-bit RGB pixels to the display output stage under a valid/busy handshake. It sits between the memory arbiter and the display timing generator, and is the read-side counterpart of the display clear/write sequencer.

## Interface
- P_AREA_H, 640, pixels per line
- P_AREA_V, 480, lines per frame
- P_AREAA_HV_N, 19, width of pixel counters (must hold P_AREA_H*P_AREA_V)
- P_MEM_ADDR_N, 23, memory address width
- P_FIFO_DEPTH, 16, pixel FIFO entries (power of two)
- P_FIFO_DEPTH_N, 4, log2(P_FIFO_DEPTH)

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous reset, same effect as inRESET
- iIF_START  in  1  frame-read request; sampled only in IDLE
- iIF_BASE_ADDR  in  P_MEM_ADDR_N  frame base address, latched with iIF_START
- oIF_BUSY  out  1  high whenever state ≠ IDLE
- oIF_FINISH  out  1  one-cycle pulse in END
- oMEM_REQ  out  1  read request; accepted in the same cycle it is high
- iMEM_BUSY  in  1  memory cannot accept a request
- oMEM_ADDR  out  P_MEM_ADDR_N  base + request index
- iMEM_RD_VALID  in  1  read data return, in request order, latency ≥ 1
- iMEM_RD_DATA  in  24  {R,G,B}
- oPIX_VALID  out  1  pixel transferred this cycle
- iPIX_BUSY  in  1  output stage stalls
- oPIX_DATA  out  24  FIFO head {R,G,B}
- oUNDERFLOW  out  1  sticky underflow flag (see Configuration)

## Operation
- States: IDLE → READ → END → IDLE. Reset and iRESET_SYNC force IDLE; all counters, FIFO pointers and the latched base are cleared. The encoding default branch also returns to IDLE.
- IDLE: if iIF_START, latch iIF_BASE_ADDR, clear the counters, and go to READ.
- READ, request side:
  - can_issue = (req_cnt < H*V) && (fifo_cnt + outstanding < P_FIFO_DEPTH).
  - oMEM_REQ = can_issue && !iMEM_BUSY.
  - On oMEM_REQ: req_cnt+1, outstanding+1.
- Return side:
  - iMEM_RD_VALID pushes iMEM_RD_DATA into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO is never full on a push. A push arriving while full is dropped. Returns arriving in IDLE are discarded.
- Output side:
  - oPIX_VALID = (state == READ) && fifo_cnt ≠ 0 && !iPIX_BUSY.
  - Each oPIX_VALID pops the FIFO and increments pix_cnt.
  - oPIX_DATA is the FIFO head and is combinational from storage.
- Request, push and pop may all occur in the same cycle. fifo_cnt changes by push − pop, and outstanding changes by req − ret.
- READ → END when pix_cnt == H*V. END lasts one cycle, then IDLE.
- Width rules:
  - oMEM_ADDR = base + zero-extended req_cnt, modulo 2^P_MEM_ADDR_N (wraps silently).
  - fifo_cnt and outstanding are P_FIFO_DEPTH_N+1 bits wide.
  - FIFO pointers are P_FIFO_DEPTH_N bits wide and wrap naturally.

## Timing
- Reset values: oIF_BUSY=0, oIF_FINISH=0, oMEM_REQ=0, oMEM_ADDR=0, oPIX_VALID=0, oPIX_DATA=0 (storage cleared), oUNDERFLOW=0.
- iIF_START in cycle t → state READ at t+1. The first oMEM_REQ can occur at t+1 (address = base).
- Return data pushed at cycle r is poppable at r+1 (registered FIFO count).
- The last pop at cycle p → oIF_FINISH high at p+1, oIF_BUSY low at p+2.
- iIF_START during READ/END is ignored.
- iRESET_SYNC mid-frame aborts the frame at the next edge. No oIF_FINISH is generated.

## Configuration
- GCI_STD_DISPLAY_FB_READER_UNDERFLOW_EN defined:
  - oUNDERFLOW sets (sticky) on any cycle in READ with 0 < pix_cnt < H*V, fifo_cnt == 0 and !iPIX_BUSY.
  - It clears on accepted iIF_START, iRESET_SYNC or inRESET.
- Not defined: oUNDERFLOW is tied to 0 and the detection logic is absent.

## Test plan
- H=4, V=2, depth 4, base 0x100, memory latency 1, iPIX_BUSY=0:
  - Addresses 0x100..0x107 are requested in order.
  - 8 pixels are out, matching the returned data.
  - oIF_FINISH pulses once, then oIF_BUSY=0.
- Same, iPIX_BUSY held 1:
  - Exactly 4 requests are issued, then oMEM_REQ stays 0.
  - Release busy → the remaining 4 requests are issued and all 8 pixels are delivered with no loss.
- Latency 3 with iMEM_BUSY toggling every other cycle:
  - outstanding + fifo_cnt never exceeds 4.
  - Pixel order is preserved.
- Base 0x7FFFFE, H*V=8:
  - oMEM_ADDR sequence is 0x7FFFFE, 0x7FFFFF, 0x000000..0x000005.
- iRESET_SYNC after 3 pixels:
  - The next cycle shows IDLE with all outputs at reset values and no oIF_FINISH.
  - A new iIF_START runs a full frame correctly.
- Macro defined, latency 6, iPIX_BUSY=0:
  - oUNDERFLOW sets after the first pixel when the FIFO empties.
  - It stays 1 through END.
  - It clears on the next iIF_START.
